// File: rtl/klp32_lsu_ctrl.sv
// Load/store sequencer between the KLP32V1 execute stage and a word-wide single-port RAM.
// Sub-word stores use read-modify-write; misaligned or illegal requests complete with an error and never reach the RAM.
module klp32_lsu_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [2:0]        i_funct3,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_stall,
    output logic              o_done,
    output logic              o_err,
    output logic [31:0]       o_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD    = 3'd1;
    localparam logic [2:0] ST_LDCAP = 3'd2;
    localparam logic [2:0] ST_MERGE = 3'd3;
    localparam logic [2:0] ST_WR    = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic [2:0]        state_r;
    logic [ADDR_W+1:0] addr_r;
    logic [2:0]        funct3_r;
    logic              we_r;
    logic [31:0]       wdata_r;
    logic              err_r;
    logic [31:0]       merge_r;
    logic [31:0]       rdata_r;
    logic              bad_s;

    function automatic logic access_bad(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic legal;
        logic mis;
        case (f3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = ~we;
            default:                legal = 1'b0;
        endcase
        case (f3[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return ~legal | mis;
    endfunction

    function automatic logic [31:0] lane_extend(input logic [31:0] word, input logic [2:0] f3, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        if (off[1]) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] wd,
                                               input logic [2:0] f3, input logic [1:0] off);
        logic [31:0] r;
        r = word;
        case (f3[1:0])
            2'b00: begin
                case (off)
                    2'd0:    r[7:0]   = wd[7:0];
                    2'd1:    r[15:8]  = wd[7:0];
                    2'd2:    r[23:16] = wd[7:0];
                    2'd3:    r[31:24] = wd[7:0];
                    default: r = word;
                endcase
            end
            2'b01: begin
                if (off[1]) begin
                    r[31:16] = wd[15:0];
                end else begin
                    r[15:0] = wd[15:0];
                end
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    assign bad_s   = access_bad(i_we, i_funct3, i_addr[1:0]);
    assign o_done  = (state_r == ST_DONE);
    assign o_err   = o_done & err_r;
    assign o_rdata = rdata_r;
    assign o_stall = i_req & ~o_done;

    // Sequencer state, request capture and load/merge data registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            addr_r   <= '0;
            funct3_r <= 3'b000;
            we_r     <= 1'b0;
            wdata_r  <= 32'h00000000;
            err_r    <= 1'b0;
            merge_r  <= 32'h00000000;
            rdata_r  <= 32'h00000000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_req) begin
                        addr_r   <= i_addr[ADDR_W+1:0];
                        funct3_r <= i_funct3;
                        we_r     <= i_we;
                        wdata_r  <= i_wdata;
                        err_r    <= bad_s;
                        if (i_we) begin
                            rdata_r <= 32'h00000000;
                        end else begin
                            rdata_r <= rdata_r;
                        end
                        if (bad_s) begin
                            state_r <= ST_DONE;
                        end else if (i_we && (i_funct3 == 3'b010)) begin
                            state_r <= ST_WR;
                        end else begin
                            state_r <= ST_RD;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD:    state_r <= we_r ? ST_MERGE : ST_LDCAP;
                ST_LDCAP: begin
                    rdata_r <= lane_extend(i_mem_rdata, funct3_r, addr_r[1:0]);
                    state_r <= ST_DONE;
                end
                ST_MERGE: begin
                    merge_r <= lane_merge(i_mem_rdata, wdata_r, funct3_r, addr_r[1:0]);
                    state_r <= ST_WR;
                end
                ST_WR:    state_r <= ST_DONE;
                ST_DONE:  state_r <= ST_IDLE;
                default:  state_r <= ST_IDLE;
            endcase
        end
    end

    // RAM port decode; enables are gated by reset so an aborted access never lands.
    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = addr_r[ADDR_W+1:2];
        o_mem_wdata = merge_r;
        if (state_r == ST_RD) begin
            o_mem_en = reset;
        end else if (state_r == ST_WR) begin
            o_mem_en = reset;
            o_mem_we = reset;
        end else begin
            o_mem_en = 1'b0;
            o_mem_we = 1'b0;
        end
        if (funct3_r[1:0] == 2'b10) begin
            o_mem_wdata = wdata_r;
        end else begin
            o_mem_wdata = merge_r;
        end
    end

endmodule

// File: tb/tb_klp32_lsu_ctrl.sv
// Randomized bench for klp32_lsu_ctrl with a RAM model and a byte-level reference of loads/stores.
module tb_klp32_lsu_ctrl;
    localparam int AW = 10;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req;
    logic          i_we;
    logic [2:0]    i_funct3;
    logic [31:0]   i_addr;
    logic [31:0]   i_wdata;
    logic          o_stall;
    logic          o_done;
    logic          o_err;
    logic [31:0]   o_rdata;
    logic          o_mem_en;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_wdata;
    logic [31:0]   i_mem_rdata;

    logic [31:0] ram [0:(1<<AW)-1];
    logic [31:0] model_mem [0:NW-1];
    int tests = 0;
    int fails = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    klp32_lsu_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .i_req(i_req), .i_we(i_we), .i_funct3(i_funct3),
        .i_addr(i_addr), .i_wdata(i_wdata), .o_stall(o_stall), .o_done(o_done),
        .o_err(o_err), .o_rdata(o_rdata), .o_mem_en(o_mem_en), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM plus access counters
    always @(posedge clk) begin
        if (o_mem_en) begin
            if (o_mem_we) begin
                ram[o_mem_addr] <= o_mem_wdata;
                wr_cnt = wr_cnt + 1;
            end else begin
                i_mem_rdata <= ram[o_mem_addr];
                rd_cnt = rd_cnt + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle compare: stall rule and no RAM cycle under reset
    always @(negedge clk) begin
        if (reset !== 1'bx) begin
            check("stall", {31'd0, o_stall}, {31'd0, i_req & ~o_done});
            if (!reset) check("mem_en_in_reset", {31'd0, o_mem_en}, 32'd0);
        end
    end

    task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output int lat, output int nrd,
                                output int nwr, output logic err, output logic [31:0] rdata,
                                output logic chk_rdata);
        int size;
        int off;
        int widx;
        logic legal;
        logic [31:0] word;
        logic [31:0] val;
        logic [31:0] mask;
        legal = we ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size = 1 << f3[1:0];
        off = int'(addr % 4);
        widx = int'((addr / 4) % NW);
        err = !legal || ((addr % size) != 0);
        word = model_mem[widx];
        rdata = 32'd0;
        chk_rdata = we;
        if (err) begin
            lat = 1; nrd = 0; nwr = 0;
        end else if (!we) begin
            lat = 3; nrd = 1; nwr = 0;
            val = word >> (8 * off);
            if (size == 1) begin
                val = val % 256;
                if (f3 == 3'd0 && val >= 128) val = val - 32'd256;
            end else if (size == 2) begin
                val = val % 65536;
                if (f3 == 3'd1 && val >= 32768) val = val - 32'd65536;
            end
            rdata = val;
            chk_rdata = 1'b1;
        end else if (size == 4) begin
            lat = 2; nrd = 0; nwr = 1;
            model_mem[widx] = wdata;
        end else begin
            lat = 4; nrd = 1; nwr = 1;
            mask = ((size == 1) ? 32'h000000FF : 32'h0000FFFF) << (8 * off);
            model_mem[widx] = (word & ~mask) | ((wdata << (8 * off)) & mask);
        end
    endtask

    task automatic ram_compare();
        int mism = 0;
        for (int w = 0; w < NW; w++) if (ram[w] !== model_mem[w]) mism++;
        check("ram_contents", mism, 32'd0);
    endtask

    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit hold, input bit use_pin,
                       input logic [31:0] pin);
        int lat, nrd, nwr, n;
        logic err, chk;
        logic [31:0] rdata;
        bit seen;
        model_access(we, f3, addr, wdata, lat, nrd, nwr, err, rdata, chk);
        i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
        rd_cnt = 0; wr_cnt = 0;
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (o_done) seen = 1'b1;
        end
        check("done_latency", n, lat);
        if (seen) begin
            check("err", {31'd0, o_err}, {31'd0, err});
            if (chk) check("rdata", o_rdata, rdata);
            check("ram_reads", rd_cnt, nrd);
            check("ram_writes", wr_cnt, nwr);
            if (use_pin) begin
                check("model_pin", rdata, pin);
                check("rdata_pin", o_rdata, pin);
            end
        end
        ram_compare();
        if (!hold) i_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic abort_sb(input int stage);
        i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'b000; i_addr = 32'h00000009; i_wdata = $urandom;
        rd_cnt = 0; wr_cnt = 0;
        repeat (stage) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        i_req = 1'b0;
        check("abort_done", {31'd0, o_done}, 32'd0);
        check("abort_err", {31'd0, o_err}, 32'd0);
        check("abort_rdata", o_rdata, 32'd0);
        check("abort_mem_en", {31'd0, o_mem_en}, 32'd0);
        check("abort_writes", wr_cnt, 32'd0);
        ram_compare();
        @(posedge clk); #1;
        run(1'b0, 3'b010, 32'h00000008, 32'd0, 1'b0, 1'b1, model_mem[2]);
    endtask

    initial begin
        logic [31:0] wd;
        reset = 1'b0; i_req = 1'b0; i_we = 1'b0; i_funct3 = 3'b000; i_addr = 32'd0; i_wdata = 32'd0;
        for (int w = 0; w < (1 << AW); w++) ram[w] = $urandom;
        for (int w = 0; w < NW; w++) model_mem[w] = ram[w];
        ram[2] = 32'h80FF7F02;
        model_mem[2] = 32'h80FF7F02;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_err", {31'd0, o_err}, 32'd0);
        check("rst_rdata", o_rdata, 32'd0);
        check("rst_mem_en", {31'd0, o_mem_en}, 32'd0);
        check("rst_stall", {31'd0, o_stall}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        run(1'b0, 3'b010, 32'h00000008, 32'd0, 1'b0, 1'b1, 32'h80FF7F02);
        run(1'b0, 3'b000, 32'h0000000B, 32'd0, 1'b0, 1'b1, 32'hFFFFFF80);
        run(1'b0, 3'b100, 32'h0000000B, 32'd0, 1'b0, 1'b1, 32'h00000080);
        run(1'b0, 3'b001, 32'h0000000A, 32'd0, 1'b0, 1'b1, 32'hFFFF80FF);
        run(1'b0, 3'b101, 32'h0000000A, 32'd0, 1'b0, 1'b1, 32'h000080FF);
        run(1'b0, 3'b000, 32'h00000008, 32'd0, 1'b0, 1'b1, 32'h00000002);
        run(1'b1, 3'b000, 32'h00000009, 32'h123456AA, 1'b0, 1'b0, 32'd0);
        check("sb_word", ram[2], 32'h80FFAA02);
        run(1'b1, 3'b001, 32'h0000000A, 32'h0000BEEF, 1'b0, 1'b0, 32'd0);
        check("sh_word", ram[2], 32'hBEEFAA02);

        run(1'b0, 3'b001, 32'h00000009, 32'd0, 1'b0, 1'b0, 32'd0);
        run(1'b1, 3'b010, 32'h00000006, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0);
        run(1'b0, 3'b011, 32'h00000010, 32'd0, 1'b0, 1'b0, 32'd0);

        abort_sb(2);
        abort_sb(3);

        wd = $urandom;
        run(1'b1, 3'b010, 32'h00000014, wd, 1'b1, 1'b0, 32'd0);
        run(1'b0, 3'b010, 32'h00000014, 32'd0, 1'b0, 1'b1, wd);

        for (int k = 0; k < 300; k++) begin
            run(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom & 32'hFFFFF03F,
                $urandom, 1'($urandom_range(0, 1)), 1'b0, 32'd0);
        end
        i_req = 1'b0;
        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/klp32_lsu_ctrl.md
# klp32_lsu_ctrl

Load/store sequencer between the KLP32V1 core datapath and a single-port, word-wide synchronous data RAM. It takes one memory request at a time from the core's execute stage and turns it into RAM cycles. Sub-word loads are sign- or zero-extended. Sub-word stores are done as read-modify-write because the RAM has no byte enables. While an access is in flight it stalls the core's PC, and it flags misaligned or illegal accesses without touching memory.

## Interface
Parameters:
- ADDR_W, default 10: RAM word-address width; the RAM holds 2^ADDR_W words.

Ports:
- clk  in  1: rising-edge clock.
- reset  in  1: synchronous, active-low reset. Sampled at the rising edge of clk; 0 means reset.
- i_req  in  1: a memory instruction is present; held until o_done.
- i_we  in  1: 1 = store, 0 = load.
- i_funct3  in  3: RV32I width/sign field.
- i_addr  in  32: byte address (ALU result).
- i_wdata  in  32: store data (rs2).
- o_stall  out  1: i_req & ~o_done; freezes the core's PC and register write.
- o_done  out  1: one-cycle completion pulse.
- o_err  out  1: valid with o_done; 1 = misaligned or illegal access.
- o_rdata  out  32: extended load result, valid while o_done=1.
- o_mem_en  out  1: RAM cycle enable.
- o_mem_we  out  1: RAM write enable.
- o_mem_addr  out  ADDR_W: word address = latched addr[ADDR_W+1:2].
- o_mem_wdata  out  32: RAM write word.
- i_mem_rdata  in  32: RAM read word, valid in the cycle after the RAM samples a read.

## Operation
- Request registers (addr, funct3, we, wdata) are latched only in IDLE, at the first edge where i_req=1.
- o_mem_* are decoded from the state and the latched registers only; there is no combinational path from i_* to o_mem_*.
- Legal loads: funct3 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- Legal stores: 000 sb, 001 sh, 010 sw.
- Anything else is illegal.
- Misaligned means: half access with addr[0]=1, or word access with addr[1:0]≠00.
- Byte lanes are little-endian:
  - byte at offset k = word[8k+7:8k];
  - half at offset 2h = word[16h+15:16h].
- FSM states: IDLE, RD, LDCAP, MERGE, WR, DONE.
  - IDLE, on accepting a request:
    - illegal or misaligned → DONE with err=1;
    - load or sb/sh → RD;
    - sw → WR.
  - RD: o_mem_en=1, o_mem_we=0. Next state is LDCAP for a load, MERGE for a store.
  - LDCAP: o_rdata register ← extended lane of i_mem_rdata. → DONE.
  - MERGE: merge register ← i_mem_rdata with the addressed byte/half replaced by the low byte/half of wdata. → WR.
  - WR: o_mem_en=1, o_mem_we=1, o_mem_wdata = merge register (sb/sh) or wdata (sw). → DONE.
  - DONE: o_done=1, o_err = latched err. → IDLE unconditionally.
- If i_req is still high in IDLE after DONE, it is treated as a new request (the core has advanced to the next instruction).
- o_rdata holds its value until the next LDCAP; on stores it is 0.
- Exactly one RAM write occurs per legal store; illegal or misaligned requests issue no RAM cycle.

## Timing
- Cycle 0 is the cycle in which the accepting edge occurs.
- o_done is high in cycle:
  - 1 for an error;
  - 2 for sw;
  - 3 for a load;
  - 4 for sb/sh.
- RAM read issued in RD is sampled by the RAM at the end of RD; i_mem_rdata is consumed in LDCAP or MERGE.
- o_stall is combinational and is high from the moment i_req rises until the DONE cycle, in which it is 0.
- Reset (reset=0 at an edge):
  - state ← IDLE;
  - o_done, o_err, o_rdata, the merge register and the request registers ← 0.
- o_mem_en and o_mem_we are ANDed with reset, so no RAM cycle is issued while reset=0.
- A reset asserted during RD, MERGE or WR aborts the access: no write reaches the RAM and no o_done pulse is produced.
- Back-to-back accesses: minimum one IDLE cycle between DONE and the next acceptance.

## Test plan
- Preload word 2 (byte addr 0x8) = 0x80FF7F02; lw at 0x8 → o_rdata=0x80FF7F02, o_err=0, o_done in cycle 3, one RAM read and no write.
- Sub-word loads on word 2:
  - lb 0xB → 0xFFFFFF80;
  - lbu 0xB → 0x00000080;
  - lh 0xA → 0xFFFF80FF;
  - lhu 0xA → 0x000080FF;
  - lb 0x8 → 0x00000002.
- Sub-word stores on word 2:
  - sb wdata=0x123456AA at 0x9 → word 2 becomes 0x80FFAA02, sequence RD,MERGE,WR, o_done in cycle 4, exactly one write;
  - then sh wdata=0xBEEF at 0xA → 0xBEEFAA02.
- Errors:
  - lh at 0x9 → o_err=1 in cycle 1, o_mem_en never high;
  - sw at 0x6 → same behaviour;
  - load with funct3=011 → o_err=1.
- Reset abort: drive reset=0 for one edge during MERGE of an sb → no RAM write, word unchanged, all outputs 0, state IDLE; the next lw completes normally in cycle 3.
- Stall and back-to-back: hold i_req high across sw then lw → o_stall=1 except in the DONE cycles, the second request is accepted one cycle after the first DONE, and the lw returns the word just stored.
